// File: rtl/noc_serial_receiver.sv
// noc_serial_receiver: receiving endpoint of the serial NoC protocol.
// Reassembles a HEADER / DATA... / TAIL flit stream into PACKET_BITS of payload
// plus the header padding field, and holds the result in a one-entry output
// buffer until the local consumer acknowledges it.
//
// Flit layout on down_flit: {type[1:0], data[FLIT_DATA_WIDTH-1:0]}
//   type 2'd1 = HEADER, 2'd2 = DATA, 2'd3 = TAIL, 2'd0 = undefined (treated as
//   a violation whenever it arrives with down_enable set).
// Header padding sits in the low PADDING_BITS of the header data field. With
// PADDING_BITS == 0 the padding port keeps one bit and always reads 0.
module noc_serial_receiver #(
    parameter int FLIT_DATA_WIDTH = 8,
    parameter int PACKET_BITS     = 16,
    parameter int PADDING_BITS    = 0,
    localparam int PW = (PADDING_BITS > 0) ? PADDING_BITS : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         down_enable,
    input  logic [FLIT_DATA_WIDTH+1:0]   down_flit,
    output logic                         down_ack,
    output logic                         down_rej,
    output logic                         valid,
    output logic [PACKET_BITS-1:0]       packet,
    output logic [PW-1:0]                padding,
    input  logic                         rd_ack,
    output logic                         err
);
    localparam int W       = FLIT_DATA_WIDTH;
    localparam int N_FLITS = (PACKET_BITS + W - 1) / W;
    localparam int CW      = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_FLITS - 1);

    localparam logic [1:0] FLIT_HEADER = 2'd1;
    localparam logic [1:0] FLIT_DATA   = 2'd2;
    localparam logic [1:0] FLIT_TAIL   = 2'd3;

    typedef enum logic {IDLE, RECEIVING} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [N_FLITS-1:0][W-1:0]    asm_q, asm_d, asm_wr;
    logic [N_FLITS*W-1:0]         asm_wr_flat;
    logic [PW-1:0]                pad_hdr_q, pad_hdr_d;
    logic                         valid_q, valid_d;
    logic [PACKET_BITS-1:0]       packet_q, packet_d;
    logic [PW-1:0]                padding_q, padding_d;
    logic                         err_q, err_d;

    logic [1:0]                   flit_type;
    logic [W-1:0]                 flit_data;
    logic                         free;

    // Extract the padding field from a header flit's data (inverse of the
    // sender's header build).
    function automatic logic [PW-1:0] header2_padding(input logic [W-1:0] d);
        if (PADDING_BITS == 0) return '0;
        return d[PW-1:0];
    endfunction

    assign flit_type = down_flit[W+1:W];
    assign flit_data = down_flit[W-1:0];
    // A buffer being drained this cycle counts as free.
    assign free      = ~valid_q | rd_ack;

    assign valid   = valid_q;
    assign packet  = packet_q;
    assign padding = padding_q;
    assign err     = err_q;

    // Assembly image with the current flit merged in at the current chunk slot;
    // the TAIL path takes the packet straight from here.
    always_comb begin
        asm_wr         = asm_q;
        asm_wr[cnt_q]  = flit_data;
        asm_wr_flat    = asm_wr;
    end

    // Next-state, output-buffer update and same-cycle ack/rej decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        pad_hdr_d = pad_hdr_q;
        packet_d  = packet_q;
        padding_d = padding_q;
        valid_d   = valid_q & ~rd_ack;
        err_d     = 1'b0;
        down_ack  = 1'b0;
        down_rej  = 1'b0;
        case (state_q)
            IDLE: begin
                if (down_enable) begin
                    if (flit_type == FLIT_HEADER) begin
                        if (free) begin
                            down_ack  = 1'b1;
                            pad_hdr_d = header2_padding(flit_data);
                            asm_d     = '0;
                            cnt_d     = '0;
                            state_d   = RECEIVING;
                        end else begin
                            down_rej  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECEIVING: begin
                if (down_enable && flit_type == FLIT_DATA && cnt_q < LAST) begin
                    down_ack = 1'b1;
                    asm_d    = asm_wr;
                    cnt_d    = cnt_q + CW'(1);
                end else if (down_enable && flit_type == FLIT_TAIL && cnt_q == LAST) begin
                    down_ack  = 1'b1;
                    packet_d  = asm_wr_flat[PACKET_BITS-1:0];
                    padding_d = pad_hdr_q;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    // Early TAIL, overlong DATA, stray HEADER or dropped enable:
                    // drop the partial packet, leave the output buffer alone.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            down_ack = 1'b0;
            down_rej = 1'b0;
        end
    end

    // State and output buffer registers; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            asm_q     <= '0;
            pad_hdr_q <= '0;
            valid_q   <= 1'b0;
            packet_q  <= '0;
            padding_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            pad_hdr_q <= pad_hdr_d;
            valid_q   <= valid_d;
            packet_q  <= packet_d;
            padding_q <= padding_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_noc_serial_receiver.sv
// Bench for noc_serial_receiver: 16-bit/4-bit-padding instance (a_*) and an
// 8-bit single-flit instance (b_*). Expected values come from the protocol
// rules: the payload chosen by the bench, split into bytes with arithmetic,
// and a one-entry buffer model (m_valid / m_pkt / m_pad).
module tb_noc_serial_receiver;
    localparam int W = 8;
    localparam logic [1:0] T_HDR = 2'd1, T_DATA = 2'd2, T_TAIL = 2'd3;

    logic clk = 1'b0;
    logic rst;

    logic          a_en, a_ack, a_rej, a_valid, a_rd_ack, a_err;
    logic [W+1:0]  a_flit;
    logic [15:0]   a_packet;
    logic [3:0]    a_padding;

    logic          b_en, b_ack, b_rej, b_valid, b_rd_ack, b_err;
    logic [W+1:0]  b_flit;
    logic [7:0]    b_packet;
    logic [3:0]    b_padding;

    int checks = 0;
    int failures = 0;

    noc_serial_receiver #(.FLIT_DATA_WIDTH(W), .PACKET_BITS(16), .PADDING_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .down_enable(a_en), .down_flit(a_flit),
        .down_ack(a_ack), .down_rej(a_rej), .valid(a_valid), .packet(a_packet),
        .padding(a_padding), .rd_ack(a_rd_ack), .err(a_err));

    noc_serial_receiver #(.FLIT_DATA_WIDTH(W), .PACKET_BITS(8), .PADDING_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .down_enable(b_en), .down_flit(b_flit),
        .down_ack(b_ack), .down_rej(b_rej), .valid(b_valid), .packet(b_packet),
        .padding(b_padding), .rd_ack(b_rd_ack), .err(b_err));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic en, input logic [1:0] t, input logic [7:0] d);
        a_en   = en;
        a_flit = {t, d};
    endtask

    // HEADER / DATA(low byte) / TAIL(high byte); rd_ack as set by the caller is
    // held for the header cycle only. Counts ack, rej and err observations.
    task automatic send_pkt(input logic [15:0] p, input logic [3:0] pad,
                            output int acks, output int rejs, output int errs);
        acks = 0; rejs = 0; errs = 0;
        drv(1'b1, T_HDR, {4'($urandom), pad});
        @(negedge clk); acks += int'(a_ack); rejs += int'(a_rej);
        step(); errs += int'(a_err); a_rd_ack = 1'b0;
        drv(1'b1, T_DATA, 8'(p % 256));
        @(negedge clk); acks += int'(a_ack); rejs += int'(a_rej);
        step(); errs += int'(a_err);
        drv(1'b1, T_TAIL, 8'(p / 256));
        @(negedge clk); acks += int'(a_ack); rejs += int'(a_rej);
        step(); errs += int'(a_err);
        drv(1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1'b1, T_HDR, 8'h0A);
        step(); step();
        rst = 1'b0;
        drv(1'b0, 2'd0, 8'h00);
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", a_valid); end
        checks++; if (a_packet !== 16'h0) begin failures++; $display("FAIL reset_packet got=%0h exp=0", a_packet); end
        checks++; if (a_padding !== 4'h0) begin failures++; $display("FAIL reset_padding got=%0h exp=0", a_padding); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", a_err); end
        @(negedge clk);
        checks++; if ({a_ack, a_rej} !== 2'b00) begin failures++; $display("FAIL reset_ackrej got=%0b exp=00", {a_ack, a_rej}); end
        step();
    endtask

    task automatic test_basic();
        int acks, rejs, errs;
        send_pkt(16'h1234, 4'hA, acks, rejs, errs);
        checks++; if (acks != 3) begin failures++; $display("FAIL basic_acks got=%0d exp=3", acks); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", a_valid); end
        checks++; if (a_packet !== 16'h1234) begin failures++; $display("FAIL basic_packet got=%0h exp=1234", a_packet); end
        checks++; if (a_padding !== 4'hA) begin failures++; $display("FAIL basic_padding got=%0h exp=a", a_padding); end
        checks++; if (errs != 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", errs); end
        a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_rdack_valid got=%0h exp=0", a_valid); end
    endtask

    task automatic test_reject();
        int acks, rejs, errs;
        send_pkt(16'h1111, 4'h1, acks, rejs, errs);
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, T_HDR, 8'h07);
            @(negedge clk);
            checks++; if ({a_ack, a_rej} !== 2'b01) begin failures++; $display("FAIL reject_ackrej got=%0b exp=01", {a_ack, a_rej}); end
            step();
            checks++; if (a_packet !== 16'h1111 || a_valid !== 1'b1) begin failures++; $display("FAIL reject_hold got=%0h/%0h exp=1111/1", a_packet, a_valid); end
        end
        a_rd_ack = 1'b1;
        send_pkt(16'h9C3E, 4'h6, acks, rejs, errs);
        checks++; if (acks != 3 || rejs != 0) begin failures++; $display("FAIL reject_retry got=%0d/%0d exp=3/0", acks, rejs); end
        checks++; if (a_packet !== 16'h9C3E || a_padding !== 4'h6) begin failures++; $display("FAIL reject_second got=%0h/%0h exp=9c3e/6", a_packet, a_padding); end
        a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
    endtask

    task automatic test_early_tail();
        int acks, rejs, errs;
        drv(1'b1, T_HDR, 8'h02);
        step();
        drv(1'b1, T_TAIL, 8'h77);
        @(negedge clk);
        checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL early_tail_ack got=%0h exp=0", a_ack); end
        step();
        drv(1'b0, 2'd0, 8'h00);
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL early_tail_err got=%0h exp=1", a_err); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL early_tail_valid got=%0h exp=0", a_valid); end
        step();
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL early_tail_pulse got=%0h exp=0", a_err); end
        send_pkt(16'h0F1E, 4'h3, acks, rejs, errs);
        checks++; if (acks != 3 || a_packet !== 16'h0F1E) begin failures++; $display("FAIL early_tail_recover got=%0d/%0h exp=3/0f1e", acks, a_packet); end
        a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acks, rejs, errs, e1;
        send_pkt(16'hBEEF, 4'h5, acks, rejs, e1);
        checks++; if (a_packet !== 16'hBEEF || a_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0h/%0h exp=beef/1", a_packet, a_valid); end
        a_rd_ack = 1'b1;
        send_pkt(16'hCAFE, 4'h9, acks, rejs, errs);
        checks++; if (acks != 3 || rejs != 0 || errs + e1 != 0) begin failures++; $display("FAIL b2b_hs got=%0d/%0d/%0d exp=3/0/0", acks, rejs, errs + e1); end
        checks++; if (a_packet !== 16'hCAFE || a_padding !== 4'h9 || a_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=cafe/9/1", a_packet, a_padding, a_valid); end
    endtask

    task automatic test_reset_mid();
        int acks, rejs, errs;
        a_rd_ack = 1'b1;
        drv(1'b1, T_HDR, 8'h01);
        step(); a_rd_ack = 1'b0;
        drv(1'b1, T_DATA, 8'h11);
        step();
        rst = 1'b1;
        drv(1'b1, T_TAIL, 8'h22);
        step();
        rst = 1'b0;
        drv(1'b1, T_DATA, 8'h33);
        checks++; if (a_valid !== 1'b0 || a_packet !== 16'h0) begin failures++; $display("FAIL rstmid_buffer got=%0h/%0h exp=0/0", a_valid, a_packet); end
        @(negedge clk);
        checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%0h exp=0", a_ack); end
        step();
        drv(1'b0, 2'd0, 8'h00);
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL rstmid_idle_data_err got=%0h exp=1", a_err); end
        step();
        send_pkt(16'hA55A, 4'hC, acks, rejs, errs);
        checks++; if (acks != 3 || a_packet !== 16'hA55A || a_padding !== 4'hC) begin failures++; $display("FAIL rstmid_fresh got=%0d/%0h/%0h exp=3/a55a/c", acks, a_packet, a_padding); end
        a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
    endtask

    task automatic test_random();
        int acks, rejs, errs;
        logic m_valid = 1'b0;
        logic [15:0] m_pkt = '0, p;
        logic [3:0]  m_pad = '0, pad;
        for (int n = 0; n < 30; n++) begin
            p   = 16'($urandom);
            pad = 4'($urandom);
            if (m_valid) begin
                if ($urandom_range(0, 1) == 0) begin
                    for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                        drv(1'b1, T_HDR, 8'h00);
                        @(negedge clk);
                        checks++; if (a_rej !== 1'b1) begin failures++; $display("FAIL rand_rej got=%0h exp=1", a_rej); end
                        step();
                        checks++; if (a_packet !== m_pkt || a_valid !== 1'b1) begin failures++; $display("FAIL rand_stable got=%0h exp=%0h", a_packet, m_pkt); end
                    end
                    drv(1'b0, 2'd0, 8'h00);
                    a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
                    m_valid = 1'b0;
                end else begin
                    a_rd_ack = 1'b1;
                end
            end
            for (int g = 0; g < int'($urandom_range(0, 1)); g++) step();
            send_pkt(p, pad, acks, rejs, errs);
            m_valid = 1'b1; m_pkt = p; m_pad = pad;
            checks++; if (acks != 3 || rejs != 0 || errs != 0) begin failures++; $display("FAIL rand_hs got=%0d/%0d/%0d exp=3/0/0", acks, rejs, errs); end
            checks++; if (a_valid !== m_valid || a_packet !== m_pkt || a_padding !== m_pad) begin failures++; $display("FAIL rand_pkt got=%0h/%0h/%0h exp=%0h/%0h/%0h", a_valid, a_packet, a_padding, m_valid, m_pkt, m_pad); end
        end
        a_rd_ack = 1'b1; step(); a_rd_ack = 1'b0;
    endtask

    task automatic test_single_flit();
        b_en = 1'b1; b_flit = {T_HDR, 8'hE3};
        @(negedge clk);
        checks++; if (b_ack !== 1'b1) begin failures++; $display("FAIL single_hdr_ack got=%0h exp=1", b_ack); end
        step();
        b_flit = {T_TAIL, 8'h5A};
        @(negedge clk);
        checks++; if (b_ack !== 1'b1) begin failures++; $display("FAIL single_tail_ack got=%0h exp=1", b_ack); end
        step();
        b_en = 1'b0;
        checks++; if (b_valid !== 1'b1 || b_packet !== 8'h5A || b_padding !== 4'h3) begin failures++; $display("FAIL single_pkt got=%0h/%0h/%0h exp=1/5a/3", b_valid, b_packet, b_padding); end
        b_rd_ack = 1'b1; step(); b_rd_ack = 1'b0;
        b_en = 1'b1; b_flit = {T_HDR, 8'h01};
        step();
        b_flit = {T_DATA, 8'h66};
        @(negedge clk);
        checks++; if (b_ack !== 1'b0) begin failures++; $display("FAIL single_data_ack got=%0h exp=0", b_ack); end
        step();
        b_en = 1'b0;
        checks++; if (b_err !== 1'b1 || b_valid !== 1'b0) begin failures++; $display("FAIL single_data_err got=%0h/%0h exp=1/0", b_err, b_valid); end
        step();
        checks++; if (b_err !== 1'b0 || b_valid !== 1'b0) begin failures++; $display("FAIL single_after got=%0h/%0h exp=0/0", b_err, b_valid); end
    endtask

    initial begin
        a_en = 1'b0; a_flit = '0; a_rd_ack = 1'b0;
        b_en = 1'b0; b_flit = '0; b_rd_ack = 1'b0;
        test_reset();
        test_basic();
        test_reject();
        test_early_tail();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_single_flit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
